// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default widths and the default coefficient table for the FIR sequencer.
package fir_pkg;
  localparam int TAPS_DEF = 32;
  localparam int IN_W_DEF = 10;
  localparam int COEF_W_DEF = 8;
  localparam int COEF_SUM = 302;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  // Symmetric low-pass response h0..h31
  localparam int COEF_TAB [32] = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0,
                                   4, 12, 21, 30, 37, 41, 41, 37, 30, 21, 12, 4,
                                   0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
  function automatic int default_coef(input int k);
    return (k >= 0 && k < 32) ? COEF_TAB[k] : 0;
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered multiply-accumulate with synchronous clear (clear wins over enable).
module fir_mac
  import fir_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W = IN_W_DEF + COEF_W_DEF + 5
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_W-1:0]   sample,
  input  logic [COEF_W-1:0] coef,
  output logic [OUT_W-1:0]  acc
);
  localparam int PW = IN_W + COEF_W;
  logic [PW-1:0] prod;
  logic [OUT_W-1:0] acc_d, acc_q;
  always_comb begin
    prod = PW'(sample) * PW'(coef);
    acc_d = clr ? '0 : en ? acc_q + OUT_W'(prod) : acc_q;
  end
  always_ff @(posedge clock) acc_q <= reset ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one shared MAC stepped over all taps per sample.
// Define FIR_COEF_WRITE_EN for a writable coefficient file; otherwise coefficients are the package table.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int IN_W = IN_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W = IN_W + COEF_W + $clog2(TAPS)
)(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_ack
);
  localparam int AW = $clog2(TAPS);
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, cur_ptr_q, cur_ptr_d, k_q, k_d, rd_idx;
  logic [IN_W-1:0] buf_q [TAPS];
  logic [IN_W-1:0] buf_d [TAPS];
  logic [COEF_W-1:0] coef_k;
  logic accept, last;
  assign accept = in_valid & in_ready;
  assign last = k_q == AW'(TAPS - 1);
  assign rd_idx = cur_ptr_q - k_q;
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = (state_q == IDLE && accept) ? MAC :
              (state_q == MAC && last) ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cur_ptr_d = accept ? wr_ptr_q : cur_ptr_q;
    k_d = (state_q == MAC) ? k_q + 1'b1 : '0;
    buf_d = buf_q;
    if (accept) buf_d[wr_ptr_q] = in_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      cur_ptr_q <= '0;
      k_q <= '0;
      buf_q <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cur_ptr_q <= cur_ptr_d;
      k_q <= k_d;
      buf_q <= buf_d;
    end
  end
`ifdef FIR_COEF_WRITE_EN
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [COEF_W-1:0] coef_d [TAPS];
  logic coef_ack_d, coef_ack_q;
  // A write racing a sample accept is dropped so the MAC never sees a half-updated file
  always_comb begin
    coef_ack_d = state_q == IDLE && coef_we && !accept;
    coef_d = coef_q;
    if (coef_ack_d) coef_d[coef_addr] = coef_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_W'(default_coef(i));
      coef_ack_q <= 1'b0;
    end else begin
      coef_q <= coef_d;
      coef_ack_q <= coef_ack_d;
    end
  end
  assign coef_k = coef_q[k_q];
  assign coef_ack = coef_ack_q;
`else
  logic unused_coef;
  assign unused_coef = ^{coef_we, coef_addr, coef_data};
  assign coef_k = COEF_W'(default_coef(int'(k_q)));
  assign coef_ack = 1'b0;
`endif
  fir_mac #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clr    (accept),
    .en     (state_q == MAC),
    .sample (buf_q[rd_idx]),
    .coef   (coef_k),
    .acc    (out_data)
  );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: randomized bench against a sample-history convolution model.
module tb_fir_mac_sequencer;
  localparam int TAPS = 32;
  localparam int H [32] = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0,
                            4, 12, 21, 30, 37, 41, 41, 37, 30, 21, 12, 4,
                            0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
  logic clock = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, coef_we = 0, coef_ack;
  logic [9:0] in_data = 0;
  logic [22:0] out_data;
  logic [4:0] coef_addr = 0;
  logic [7:0] coef_data = 0;
  int total = 0, bad = 0;
  int mc [32];
  int unsigned hist [$];
  longint y;

  fir_mac_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ack(coef_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < hist.size(); k++) s += longint'(mc[k]) * longint'(hist[hist.size() - 1 - k]);
    return s;
  endfunction

  task automatic reset_dut();
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    hist.delete();
    mc = H;
  endtask

  task automatic wr_coef(input int a, input int d);
    @(negedge clock); coef_we = 1; coef_addr = 5'(a); coef_data = 8'(d);
    @(negedge clock); coef_we = 0;
`ifdef FIR_COEF_WRITE_EN
    chk("coef_ack", coef_ack, 1);
    mc[a] = d;
`else
    chk("coef_ack_off", coef_ack, 0);
`endif
    @(negedge clock); chk("coef_ack_pulse", coef_ack, 0);
  endtask

  // mode 0: plain, 1: coefficient write coincident with accept, 2: write during MAC
  task automatic do_sample(input int x, input int hold, input int mode, output longint res);
    int lat;
    longint exp;
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = 10'(x);
    if (mode == 1) begin coef_we = 1; coef_addr = 5'($urandom); coef_data = 8'($urandom); end
    @(negedge clock);
    in_valid = 0;
    if (mode == 1) begin coef_we = 0; chk("accept_wr_ack", coef_ack, 0); end
    hist.push_back(x);
    if (hist.size() > TAPS) void'(hist.pop_front());
    exp = model_y();
    lat = 0;
    while (!out_valid && lat < TAPS + 8) begin
      if (mode == 2 && lat == 2) begin coef_we = 1; coef_addr = 5'($urandom); coef_data = 8'($urandom); end
      if (mode == 2 && lat == 3) begin coef_we = 0; chk("mac_wr_ack", coef_ack, 0); end
      @(negedge clock); lat++;
    end
    chk("latency", lat, TAPS);
    chk("out_data", out_data, exp);
    res = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_data = 10'($urandom);
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clock); out_ready = 0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp0;
    mc = H;
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_coef_ack", coef_ack, 0);
    for (int i = 0; i < TAPS; i++) begin
      do_sample(i == 0 ? 1 : 0, 0, 0, y);
      chk("impulse", y, H[i]);
    end
    for (int i = 0; i < TAPS; i++) begin
      do_sample(1023, 0, 0, y);
      if (i == TAPS - 1) chk("step_sum", y, 308946);
    end
`ifdef FIR_COEF_WRITE_EN
    for (int k = 0; k < TAPS; k++) wr_coef(k, 255);
    for (int i = 0; i < TAPS; i++) begin
      do_sample(1023, 0, 0, y);
      if (i == TAPS - 1) chk("step_max", y, 8347680);
    end
    exp0 = 255;
`else
    exp0 = 3;
`endif
    reset_dut();
    wr_coef(0, 255);
    do_sample(1, 0, 0, y);
    chk("coef0_impulse", y, exp0);
    do_sample(500, 0, 2, y);
    do_sample(321, 5, 0, y);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) wr_coef($urandom_range(0, 31), $urandom_range(0, 255));
      do_sample($urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(0, 2), y);
    end
    @(negedge clock); in_valid = 1; in_data = 10'd777;
    @(negedge clock); in_valid = 0;
    repeat (9) @(negedge clock);
    reset = 1;
    @(negedge clock); reset = 0;
    chk("midmac_out_valid", out_valid, 0);
    chk("midmac_in_ready", in_ready, 1);
    hist.delete();
    mc = H;
    do_sample(1, 0, 0, y);
    chk("post_reset_impulse", y, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller: accepts one input sample per valid/ready handshake, stores it in a circular sample buffer, and sequences a single shared multiply-accumulate unit across all taps. It then presents the filter result on a valid/ready output. It replaces the fully parallel 32-multiplier filter where area matters more than throughput, and owns the coefficient register file that configures the datapath.

## Interface
- TAPS, 32, number of taps, power of two, ≥2
- IN_W, 10, input sample width, unsigned
- COEF_W, 8, coefficient width, unsigned
- OUT_W, IN_W+COEF_W+$clog2(TAPS) (23), output width; full precision, never overflows
- clock  in  1  clock; all state updates on its rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  IN_W  sample x[n]
- out_valid  out  1  result y[n] available
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  y[n] = Σ coef[k]·x[n−k], k=0..TAPS−1
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index k
- coef_data  in  COEF_W  coefficient value
- coef_ack  out  1  one-cycle pulse: write accepted

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, the sample is written to buffer[wr_ptr]. Then cur_ptr←wr_ptr, wr_ptr←wr_ptr+1 (mod TAPS), acc←0, k←0, →MAC.
- MAC: each cycle acc←acc+coef[k]·buffer[(cur_ptr−k) mod TAPS], k←k+1. Exactly TAPS cycles; on k=TAPS−1 the final term is added and the FSM goes →DONE.
- DONE: out_valid=1, out_data=acc, held stable until out_ready=1. On the handshake, →IDLE.
- in_ready=0 in MAC and DONE. No input skid; the producer holds in_valid/in_data.
- Buffer index wrap is modulo TAPS (natural pointer overflow, since TAPS is a power of two).
- Coefficient write is accepted only when the state is IDLE, coef_we=1, and in_valid&in_ready is not also firing that cycle. An accepted write updates coef[coef_addr] at the edge; coef_ack=1 the following cycle. Writes in MAC/DONE, or coincident with a sample accept, are dropped with no ack. The requester retries.
- Unsigned arithmetic throughout. The product is IN_W+COEF_W bits, zero-extended into OUT_W.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, out_data=0, coef_ack=0. acc=0, wr_ptr=0, all buffer entries 0, coefficients = package defaults.
- Accept at edge E0 → out_valid rises after edge E0+TAPS (TAPS cycles latency).
- Minimum sample period is TAPS+2 cycles with out_ready held high: MAC×TAPS, DONE×1, IDLE×1.
- Reset mid-MAC or mid-DONE: the result is discarded, out_valid=0, and IDLE is entered at the next cycle. The buffer is zeroed, so no history survives.

## Configuration
- FIR_COEF_WRITE_EN defined: the coefficient register file is writable as described above.
- FIR_COEF_WRITE_EN undefined: coefficients are constant from the package table. coef_we/coef_addr/coef_data are ignored, coef_ack is tied 0, and no coefficient flops are inferred. Ports remain, so the interface is unchanged.

## Structure
- Package fir_pkg:
  - FSM state enum.
  - Default width constants.
  - Default coefficient table, symmetric, h0..h31: 3,2,1, 0×7, 4,12,21,30,37,41,41,37,30,21,12,4, 0×7, 1,2,3.
  - Coefficient sum 302.
- Sub-module fir_mac: registered accumulator with clear and enable. It takes sample and coefficient, and has OUT_W output. The FSM, buffer, pointers and coefficient file stay in the top.

## Test plan
- Impulse: in_data=1, then 31 zeros, out_ready=1 → out_data sequence equals the coefficient table 3,2,1,0…,3. Each out_valid rises exactly TAPS cycles after its accept.
- Step: 32 samples of 1023 → 32nd output = 1023·302 = 308946. Then 32 samples of 1023 with all coefs written to 255 → 8347680, no overflow.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0, the held in_valid sample is not consumed. Release → handshake, IDLE next cycle.
- Coefficient write (macro on): in IDLE write coef[0]=255 → coef_ack pulses once. An impulse of 1 then yields a first output of 255. A write during MAC → no ack, coef unchanged. With the macro off, the same write has no effect and coef_ack stays 0.
- Reset mid-MAC (cycle 10 of 32): next cycle out_valid=0, in_ready=1. A subsequent impulse of 1 gives a first output of 3, confirming the buffer cleared and coefficients restored.
